airi5c_fetch_aligner: RTL and testbench



---
 rtl/airi5c_fetch_aligner_pkg.sv | 11 +
 rtl/airi5c_fetch_hold.sv | 31 +++
 rtl/airi5c_fetch_aligner.sv | 94 +++++++++
 tb/tb_airi5c_fetch_aligner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/airi5c_fetch_aligner_pkg.sv
// airi5c_fetch_aligner_pkg: shared datapath width and compressed-instruction detection
package airi5c_fetch_aligner_pkg;

    localparam int XPR_LEN = 32;
    localparam logic [1:0] RVC_NOT_COMPRESSED = 2'b11;

    function automatic logic is_rvc(input logic [1:0] low_bits);
        return low_bits != RVC_NOT_COMPRESSED;
    endfunction

endpackage

// File: rtl/airi5c_fetch_hold.sv
// airi5c_fetch_hold: buffers the upper halfword of a fetch word until it can be emitted
module airi5c_fetch_hold
    import airi5c_fetch_aligner_pkg::*;
(
    input  logic               clk,
    input  logic               nreset,
    input  logic               clear,
    input  logic               load,
    input  logic [15:0]        load_data,
    input  logic [XPR_LEN-1:0] load_pc,
    output logic               hold_v,
    output logic [15:0]        hold,
    output logic [XPR_LEN-1:0] hold_pc
);

    // clear wins so a redirect always empties the buffer
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold_v  <= 1'b0;
            hold    <= '0;
            hold_pc <= '0;
        end else if (clear) begin
            hold_v <= 1'b0;
        end else if (load) begin
            hold_v  <= 1'b1;
            hold    <= load_data;
            hold_pc <= load_pc;
        end
    end

endmodule

// File: rtl/airi5c_fetch_aligner.sv
// airi5c_fetch_aligner: splits 32-bit fetch words into 16/32-bit instructions with their PCs
module airi5c_fetch_aligner
    import airi5c_fetch_aligner_pkg::*;
#(
    parameter logic [XPR_LEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               redirect_i,
    input  logic [XPR_LEN-1:0] redirect_pc_i,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [XPR_LEN-1:0] fetch_data_i,
    input  logic [XPR_LEN-1:0] fetch_pc_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [XPR_LEN-1:0] inst_o,
    output logic [XPR_LEN-1:0] inst_pc_o,
    output logic               inst_compressed_o
);

    logic               started, skip_low, hold_v, hold_rvc, load_en, match;
    logic               r_hold_c, r_straddle, r_skip, r_low_c, r_full, emit;
    logic [15:0]        hold;
    logic [XPR_LEN-1:0] hold_pc, exp_pc, emit_inst, emit_pc;

    airi5c_fetch_hold u_hold (
        .clk       (clk),
        .nreset    (nreset),
        .clear     (redirect_i | r_hold_c),
        .load      (r_straddle | r_skip | r_low_c),
        .load_data (fetch_data_i[31:16]),
        .load_pc   (fetch_pc_i + 32'd2),
        .hold_v    (hold_v),
        .hold      (hold),
        .hold_pc   (hold_pc)
    );

    // handshake and emit-rule selection; stale words are consumed but never match
    always_comb begin
        load_en       = ~inst_valid_o | inst_ready_i;
        hold_rvc      = is_rvc(hold[1:0]);
        fetch_ready_o = started & ~redirect_i & load_en & (~hold_v | ~hold_rvc);
        match         = fetch_valid_i & fetch_ready_o & (fetch_pc_i == exp_pc);
        r_hold_c      = started & ~redirect_i & load_en & hold_v & hold_rvc;
        r_straddle    = match & hold_v & ~hold_rvc;
        r_skip        = match & ~hold_v & skip_low;
        r_low_c       = match & ~hold_v & ~skip_low & is_rvc(fetch_data_i[1:0]);
        r_full        = match & ~hold_v & ~skip_low & ~is_rvc(fetch_data_i[1:0]);
        emit          = r_hold_c | r_straddle | r_low_c | r_full;
        emit_inst     = r_hold_c   ? {16'h0, hold} :
                        r_straddle ? {fetch_data_i[15:0], hold} :
                        r_low_c    ? {16'h0, fetch_data_i[15:0]} : fetch_data_i;
        emit_pc       = (r_hold_c | r_straddle) ? hold_pc : fetch_pc_i;
    end

    // fetch-side tracking: start-up, expected word address and half-word skip after redirect
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            started  <= 1'b0;
            exp_pc   <= RESET_PC & ~32'h3;
            skip_low <= RESET_PC[1];
        end else begin
            started <= 1'b1;
            if (redirect_i) begin
                exp_pc   <= redirect_pc_i & ~32'h3;
                skip_low <= redirect_pc_i[1];
            end else begin
                if (match) exp_pc <= exp_pc + 32'd4;
                if (r_skip) skip_low <= 1'b0;
            end
        end
    end

    // output register: reloads whenever the previous instruction has left or none is held
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            inst_valid_o      <= 1'b0;
            inst_o            <= '0;
            inst_pc_o         <= '0;
            inst_compressed_o <= 1'b0;
        end else if (redirect_i) begin
            inst_valid_o <= 1'b0;
        end else if (load_en) begin
            inst_valid_o <= emit;
            if (emit) begin
                inst_o            <= emit_inst;
                inst_pc_o         <= emit_pc;
                inst_compressed_o <= is_rvc(emit_inst[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_airi5c_fetch_aligner.sv
// tb_airi5c_fetch_aligner: directed stimulus with a queue scoreboard checked by a separate monitor
module tb_airi5c_fetch_aligner;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i = '0;
    logic [31:0] fetch_pc_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b1;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_compressed_o;

    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;

    airi5c_fetch_aligner #(.RESET_PC(32'h8000_0000)) dut (
        .clk               (clk),
        .nreset            (nreset),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .fetch_valid_i     (fetch_valid_i),
        .fetch_ready_o     (fetch_ready_o),
        .fetch_data_i      (fetch_data_i),
        .fetch_pc_i        (fetch_pc_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o),
        .inst_compressed_o (inst_compressed_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    task automatic expect_inst(input logic [31:0] inst, input logic [31:0] pc, input logic comp);
        exp_q.push_back('{inst: inst, pc: pc, comp: comp});
    endtask

    task automatic send(input logic [31:0] data, input logic [31:0] pc);
        fetch_valid_i = 1'b1;
        fetch_data_i  = data;
        fetch_pc_i    = pc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fetch_ready_o) begin
                @(posedge clk);
                #1 fetch_valid_i = 1'b0;
                return;
            end
        end
        chk("fetch_accept_timeout", 32'(fetch_ready_o), 32'd1);
        fetch_valid_i = 1'b0;
    endtask

    // monitor: pops on every transfer, checks stability while stalled
    always @(negedge clk) begin
        if (nreset && inst_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_inst", inst_o, 32'hxxxx_xxxx);
            end else if (inst_ready_i) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("inst", inst_o, e.inst);
                chk("inst_pc", inst_pc_o, e.pc);
                chk("inst_comp", 32'(inst_compressed_o), 32'(e.comp));
            end else begin
                chk("stall_inst", inst_o, exp_q[0].inst);
                chk("stall_fetch_ready", 32'(fetch_ready_o), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", inst_pc_o, 32'd0);
        chk("rst_comp", 32'(inst_compressed_o), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd0);
        @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        chk("not_started_ready", 32'(fetch_ready_o), 32'd0);
        @(negedge clk);
        chk("started_ready", 32'(fetch_ready_o), 32'd1);
        @(posedge clk);
        #1;
        // two full-width instructions back to back
        expect_inst(32'h00A0_0093, 32'h8000_0000, 1'b0);
        expect_inst(32'h0000_0013, 32'h8000_0004, 1'b0);
        send(32'h00A0_0093, 32'h8000_0000);
        send(32'h0000_0013, 32'h8000_0004);
        // two compressed in one word
        expect_inst(32'h0000_4501, 32'h8000_0008, 1'b1);
        expect_inst(32'h0000_4585, 32'h8000_000A, 1'b1);
        send(32'h4585_4501, 32'h8000_0008);
        @(negedge clk);
        chk("ready_while_hold_c", 32'(fetch_ready_o), 32'd0);
        // straddle, then leftover 0x0013 completes with the next word
        expect_inst(32'h0000_4501, 32'h8000_000C, 1'b1);
        expect_inst(32'h00A0_0093, 32'h8000_000E, 1'b0);
        expect_inst(32'h0000_0013, 32'h8000_0012, 1'b0);
        expect_inst(32'h0000_4501, 32'h8000_0016, 1'b1);
        send(32'h0093_4501, 32'h8000_000C);
        send(32'h0013_00A0, 32'h8000_0010);
        send(32'h4501_0000, 32'h8000_0014);
        repeat (4) @(posedge clk);
        // redirect to a halfword target; stale word dropped, lower half skipped
        #1 redirect_i = 1'b1;
        redirect_pc_i = 32'h8000_0102;
        @(posedge clk);
        #1 redirect_i = 1'b0;
        send(32'h0000_0013, 32'h8000_0008);
        @(negedge clk);
        chk("stale_no_emit", 32'(inst_valid_o), 32'd0);
        expect_inst(32'h0000_1234, 32'h8000_0102, 1'b1);
        send(32'h1234_4501, 32'h8000_0100);
        @(negedge clk);
        chk("skip_bubble", 32'(inst_valid_o), 32'd0);
        repeat (3) @(posedge clk);
        // back-pressure for three cycles
        #1 inst_ready_i = 1'b0;
        expect_inst(32'h00A0_0093, 32'h8000_0104, 1'b0);
        expect_inst(32'h0000_4501, 32'h8000_0108, 1'b1);
        expect_inst(32'h0000_4585, 32'h8000_010A, 1'b1);
        send(32'h00A0_0093, 32'h8000_0104);
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h4585_4501;
        fetch_pc_i    = 32'h8000_0108;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 inst_ready_i = 1'b1;
        send(32'h4585_4501, 32'h8000_0108);
        repeat (4) @(posedge clk);
        // reset while a straddle half is held
        #1;
        expect_inst(32'h0000_4501, 32'h8000_010C, 1'b1);
        send(32'h0093_4501, 32'h8000_010C);
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        chk("midrst_valid", 32'(inst_valid_o), 32'd0);
        chk("midrst_ready", 32'(fetch_ready_o), 32'd0);
        @(posedge clk);
        #1 nreset = 1'b1;
        expect_inst(32'h0000_0013, 32'h8000_0000, 1'b0);
        send(32'h0000_0013, 32'h8000_0000);
        repeat (4) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
